nibble_sum_decoder: RTL and testbench



---
 rtl/nibble_sum_decoder.sv | 163 ++++++++++++++++
 tb/tb_nibble_sum_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_sum_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nibble_sum_decoder                                         |
// | Description : Recovers operand B from a nibble sum S and known operand   |
// |               A (B = S - A) using an LSB-first bit-serial subtractor     |
// |               with valid/ready handshakes on input and output. Results   |
// |               that no NIB_W-bit B can produce are flagged via out_err.   |
// | Optional    : define NIBBLE_DEC_ERRCNT_EN to build the saturating 8-bit  |
// |               error counter on err_cnt (tied to 0 otherwise).            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   1      clock, rising edge                              |
// |   rst        in   1      asynchronous reset, active-high                 |
// |   in_valid   in   1      upstream presents a (sum, a) pair               |
// |   in_ready   out  1      block can accept a pair (state == IDLE)         |
// |   in_sum     in   SUM_W  sum S                                           |
// |   in_a       in   NIB_W  known operand A                                 |
// |   out_valid  out  1      result available                                |
// |   out_ready  in   1      downstream accepts result                       |
// |   out_b      out  NIB_W  recovered operand B (0 when out_err)            |
// |   out_err    out  1      S - A outside 0 .. 2^NIB_W-1                    |
// |   busy       out  1      high in CALC or DONE                            |
// |   err_cnt    out  8      saturating error count (optional)               |
// +--------------------------------------------------------------------------+
module nibble_sum_decoder #(
  parameter int SUM_W = 5,
  parameter int NIB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic [NIB_W-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NIB_W-1:0] out_b,
  output logic             out_err,
  output logic             busy,
  output logic [7:0]       err_cnt
);

  // The serial datapath treats A as a SUM_W-bit value by prepending one zero.
  generate
    if (NIB_W != SUM_W - 1) begin : g_bad_width
      $error("nibble_sum_decoder: NIB_W must equal SUM_W-1");
    end
  endgenerate

  localparam int CNT_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(SUM_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [SUM_W-1:0]   r_sreg;
  logic [SUM_W-1:0]   r_areg;
  logic [SUM_W-1:0]   r_rreg;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_bitcnt;
  logic               r_out_valid;
  logic [NIB_W-1:0]   r_out_b;
  logic               r_out_err;

  logic               w_s0;
  logic               w_a0;
  logic               w_d;
  logic               w_borrow_next;
  logic [SUM_W-1:0]   w_r_next;
  logic               w_err;
  logic               w_last;

  // One full-subtractor bit per CALC cycle.
  assign w_s0          = r_sreg[0];
  assign w_a0          = r_areg[0];
  assign w_d           = w_s0 ^ w_a0 ^ r_borrow;
  assign w_borrow_next = (~w_s0 & w_a0) | (~(w_s0 ^ w_a0) & r_borrow);
  // Difference bits enter at the MSB, so after SUM_W shifts bit 0 is the LSB.
  assign w_r_next      = {w_d, r_rreg[SUM_W-1:1]};
  // A final borrow means S < A; a set top bit means the difference needs
  // more than NIB_W bits. Either way no NIB_W-bit B exists.
  assign w_err         = w_borrow_next | w_r_next[SUM_W-1];
  assign w_last        = (r_bitcnt == c_last_bit);

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_b     = r_out_b;
  assign out_err   = r_out_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sreg      <= '0;
      r_areg      <= '0;
      r_rreg      <= '0;
      r_borrow    <= 1'b0;
      r_bitcnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_b     <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sreg   <= in_sum;
            r_areg   <= {1'b0, in_a};
            r_rreg   <= '0;
            r_borrow <= 1'b0;
            r_bitcnt <= '0;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_sreg   <= r_sreg >> 1;
          r_areg   <= r_areg >> 1;
          r_rreg   <= w_r_next;
          r_borrow <= w_borrow_next;
          r_bitcnt <= r_bitcnt + CNT_W'(1);
          if (w_last) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_out_err   <= w_err;
            r_out_b     <= w_err ? '0 : w_r_next[NIB_W-1:0];
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef NIBBLE_DEC_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Counts DONE entries carrying an error; holds at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if ((r_state == ST_CALC) && w_last && w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_sum_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_nibble_sum_decoder                                      |
// | Description : Self-checking bench for nibble_sum_decoder. Expected B and |
// |               error flags come from plain integer subtraction.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_nibble_sum_decoder;
  localparam int SUM_W = 5;
  localparam int NIB_W = 4;
  localparam int LAT   = SUM_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic [NIB_W-1:0] in_a;
  logic             out_valid;
  logic             out_ready;
  logic [NIB_W-1:0] out_b;
  logic             out_err;
  logic             busy;
  logic [7:0]       err_cnt;

  int total = 0;
  int bad   = 0;
  int model_errs = 0;

  always #5 clk = ~clk;

  nibble_sum_decoder #(.SUM_W(SUM_W), .NIB_W(NIB_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_a     (in_a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_b    (out_b),
    .out_err  (out_err),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  // Reference: B = S - A as plain integers; invalid outside 0..2^NIB_W-1.
  function automatic void model(input int s, input int a, output int b, output logic e);
    int diff;
    diff = s - a;
    e = (diff < 0) || (diff > (1 << NIB_W) - 1);
    b = e ? 0 : diff;
  endfunction

  function automatic logic [7:0] exp_errcnt();
`ifdef NIBBLE_DEC_ERRCNT_EN
    return (model_errs > 255) ? 8'd255 : 8'(model_errs);
`else
    return 8'd0;
`endif
  endfunction

  // Offers one pair (called #1 after an edge while in_ready is high), then
  // scrambles the inputs and waits for out_valid, returning clocks since accept.
  task automatic send_and_collect(input logic [SUM_W-1:0] s, input logic [NIB_W-1:0] a,
                                  output int lat, output logic [NIB_W-1:0] b, output logic e);
    in_sum = s; in_a = a; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sum = SUM_W'($urandom);
    in_a   = NIB_W'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    b = out_b;
    e = out_err;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0; in_a = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (out_b !== '0) begin bad++; $display("FAIL reset_out_b: got %0d want 0", out_b); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat; logic [NIB_W-1:0] b; logic e;
    out_ready = 1'b1;
    send_and_collect(5'd13, 4'd4, lat, b, e);
    total++; if (lat !== LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    total++; if (b !== 4'd9) begin bad++; $display("FAIL basic_b: got %0d want 9", b); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", e); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_done: got %b want 1", busy); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_return_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_boundaries();
    int s_tab[7] = '{30, 0, 3, 20, 31, 7, 14};
    int a_tab[7] = '{15, 0, 5,  2,  0, 7, 14};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      int lat; int eb; logic ee; logic [NIB_W-1:0] b; logic e;
      model(s_tab[i], a_tab[i], eb, ee);
      send_and_collect(SUM_W'(s_tab[i]), NIB_W'(a_tab[i]), lat, b, e);
      if (ee) model_errs++;
      total++; if (lat !== LAT) begin bad++; $display("FAIL bound_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      total++; if (b !== NIB_W'(eb)) begin bad++; $display("FAIL bound_b[S=%0d,A=%0d]: got %0d want %0d", s_tab[i], a_tab[i], b, eb); end
      total++; if (e !== ee) begin bad++; $display("FAIL bound_err[S=%0d,A=%0d]: got %b want %b", s_tab[i], a_tab[i], e, ee); end
      total++; if (err_cnt !== exp_errcnt()) begin bad++; $display("FAIL bound_err_cnt[%0d]: got %0d want %0d", i, err_cnt, exp_errcnt()); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int lat; int eb; int hold; logic ee;
      logic [SUM_W-1:0] s; logic [NIB_W-1:0] a; logic [NIB_W-1:0] b; logic e;
      a = NIB_W'($urandom);
      if ($urandom_range(0, 1) == 1) s = SUM_W'(int'(a) + $urandom_range(0, 15));
      else s = SUM_W'($urandom);
      model(int'(s), int'(a), eb, ee);
      hold = $urandom_range(0, 3);
      out_ready = (hold == 0);
      send_and_collect(s, a, lat, b, e);
      if (ee) model_errs++;
      total++; if (lat !== LAT) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      total++; if (b !== NIB_W'(eb)) begin bad++; $display("FAIL rand_b[S=%0d,A=%0d]: got %0d want %0d", s, a, b, eb); end
      total++; if (e !== ee) begin bad++; $display("FAIL rand_err[S=%0d,A=%0d]: got %b want %b", s, a, e, ee); end
      total++; if (err_cnt !== exp_errcnt()) begin bad++; $display("FAIL rand_err_cnt[%0d]: got %0d want %0d", i, err_cnt, exp_errcnt()); end
      if (hold != 0) begin
        repeat (hold) begin
          @(posedge clk); #1;
          total++; if (out_valid !== 1'b1 || out_b !== NIB_W'(eb)) begin
            bad++; $display("FAIL rand_hold[%0d]: got valid=%b b=%0d want 1/%0d", i, out_valid, out_b, eb);
          end
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++; $display("FAIL rand_return_idle[%0d]: got in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [NIB_W-1:0] b; logic e;
    out_ready = 1'b0;
    send_and_collect(5'd22, 4'd10, lat, b, e);
    total++; if (lat !== LAT) begin bad++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
    total++; if (b !== 4'd12 || e !== 1'b0) begin bad++; $display("FAIL bp_result: got b=%0d err=%b want 12/0", b, e); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_sum = 5'd3; in_a = 4'd9;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_b !== 4'd12 || out_err !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL bp_stall[%0d]: got valid=%b b=%0d err=%b in_ready=%b busy=%b want 1/12/0/0/1",
                        i, out_valid, out_b, out_err, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: got valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_stray_accept: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_calc();
    int lat; logic [NIB_W-1:0] b; logic e; int seen;
    out_ready = 1'b1;
    in_sum = 5'd31; in_a = 4'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmc_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_b !== '0 || out_err !== 1'b0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL rmc_async_reset: got busy=%b valid=%b b=%0d err=%b cnt=%0d want 0/0/0/0/0",
                      busy, out_valid, out_b, out_err, err_cnt);
    end
    model_errs = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rmc_no_output: got %0d valid cycles want 0", seen); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmc_in_ready: got %b want 1", in_ready); end
    send_and_collect(5'd7, 4'd7, lat, b, e);
    total++; if (lat !== LAT) begin bad++; $display("FAIL rmc_latency: got %0d want %0d", lat, LAT); end
    total++; if (b !== 4'd0 || e !== 1'b0) begin bad++; $display("FAIL rmc_result: got b=%0d err=%b want 0/0", b, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back_errcnt();
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      int lat; int sv; int av; logic [NIB_W-1:0] b; logic e;
      sv = $urandom_range(16, 31);
      av = $urandom_range(0, sv - 16);
      send_and_collect(SUM_W'(sv), NIB_W'(av), lat, b, e);
      model_errs++;
      total++; if (e !== 1'b1 || b !== '0 || lat !== LAT) begin
        bad++; $display("FAIL b2b_result[S=%0d,A=%0d]: got err=%b b=%0d lat=%0d want 1/0/%0d", sv, av, e, b, lat, LAT);
      end
      if (i == 99 || i == 253 || i == 254 || i == 255 || i == 259) begin
        total++; if (err_cnt !== exp_errcnt()) begin bad++; $display("FAIL b2b_err_cnt[%0d]: got %0d want %0d", i, err_cnt, exp_errcnt()); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_random();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back_errcnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
